// File: rtl/nibu_pkg.sv
// Shared decode-side definitions for the issue scoreboard.
//   REG_IDX_W   : architectural register index width
//   REG_X0      : hard-wired zero register, never tracked
//   SB_LAT_W    : countdown width of a scoreboard entry
//   sb_entry_t  : {valid, rd, cnt} in-flight result record
package nibu_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;
  localparam int SB_LAT_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [SB_LAT_W-1:0]  cnt;
  } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One in-flight result slot of the issue scoreboard.
// Loads {rd, lat} on alloc, counts down every cycle while valid and frees itself
// on the write-back cycle (cnt==1), after which it clears.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   alloc                load this slot with alloc_rd / alloc_lat
//   chk_rs1/chk_use1     source 1 index and qualified read enable (rs1!=x0 already folded in)
//   chk_rs2/chk_use2     source 2 index and qualified read enable
//   chk_rd/chk_track     destination index and qualified tracked-write enable
//   raw1, raw2, waw      hazard matches against this slot while live
//   free                 slot may be (re)allocated this cycle
//   ent_nxt              slot contents after this cycle's update
module sb_entry
  import nibu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  input  logic [SB_LAT_W-1:0]  alloc_lat,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic                 chk_use1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  input  logic                 chk_use2,
  input  logic [REG_IDX_W-1:0] chk_rd,
  input  logic                 chk_track,
  output logic                 raw1,
  output logic                 raw2,
  output logic                 waw,
  output logic                 free,
  output sb_entry_t            ent_nxt
);

  localparam logic [SB_LAT_W-1:0] CNT_ONE = SB_LAT_W'(1);

  sb_entry_t ent_q, ent_d;
  logic      live;

  // At cnt==1 the result is on the write-back bus and forwarded, so the slot
  // no longer blocks anything and can be handed to a new producer.
  assign live = ent_q.valid && (ent_q.cnt > CNT_ONE);
  assign free = ~live;

  assign raw1 = live && chk_use1  && (chk_rs1 == ent_q.rd);
  assign raw2 = live && chk_use2  && (chk_rs2 == ent_q.rd);
  assign waw  = live && chk_track && (chk_rd  == ent_q.rd);

  always_comb begin
    ent_d = ent_q;
    if (alloc) begin
      ent_d.valid = 1'b1;
      ent_d.rd    = alloc_rd;
      ent_d.cnt   = alloc_lat;
    end else if (ent_q.valid) begin
      ent_d.cnt = ent_q.cnt - CNT_ONE;
      if (ent_q.cnt == CNT_ONE) ent_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign ent_nxt = ent_d;

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage hazard scheduler. Tracks multi-cycle results (loads, FPU->int
// moves, UART reads) in DEPTH countdown slots and stalls issue on RAW/WAW
// against a live slot, on a full table, or on a UART read with an empty RX FIFO.
// A stall freezes fetch/decode and the execute stage receives a bubble.
// Build option: define ISSUE_SB_PERF_EN to build the saturating stall counter;
// otherwise stall_cycles is tied to 0.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid                decode holds a legal instruction
//   issue_rs1/rs2, use_rs1/2   source indices and read enables
//   issue_rd, issue_rd_we      destination index and write enable
//   issue_lat                  cycles until rd is written (0 = forwarded ALU result)
//   issue_uart_rd, uart_empty  UART RX read and FIFO-empty status
//   branch_taken               decode instruction is squashed this cycle
//   stall                      hold fetch/decode, insert bubble
//   issue_accept               instruction issues this cycle
//   busy_mask                  registers with a pending tracked write (registered)
//   stall_cycles               saturating count of stall cycles
module issue_scoreboard
  import nibu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT_W = SB_LAT_W,  // must equal the entry count width
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic                 issue_use_rs1,
  input  logic                 issue_use_rs2,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_rd_we,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 issue_uart_rd,
  input  logic                 uart_empty,
  input  logic                 branch_taken,
  output logic                 stall,
  output logic                 issue_accept,
  output logic [31:0]          busy_mask,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam logic [SB_LAT_W-1:0] CNT_ONE = SB_LAT_W'(1);

  logic [DEPTH-1:0] raw1_v, raw2_v, waw_v, free_v, alloc_oh, alloc_v;
  sb_entry_t        ent_nxt [DEPTH];
  logic             use1, use2, track;
  logic             hazard, stall_i, alloc_en;
  logic [31:0]      busy_d, busy_q;

  // x0 reads/writes and lat==0 writes never touch the table.
  assign use1  = issue_use_rs1 && (issue_rs1 != REG_X0);
  assign use2  = issue_use_rs2 && (issue_rs2 != REG_X0);
  assign track = issue_rd_we && (issue_rd != REG_X0) && (issue_lat != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      sb_entry u_ent (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (alloc_v[gi]),
        .alloc_rd  (issue_rd),
        .alloc_lat (issue_lat),
        .chk_rs1   (issue_rs1),
        .chk_use1  (use1),
        .chk_rs2   (issue_rs2),
        .chk_use2  (use2),
        .chk_rd    (issue_rd),
        .chk_track (track),
        .raw1      (raw1_v[gi]),
        .raw2      (raw2_v[gi]),
        .waw       (waw_v[gi]),
        .free      (free_v[gi]),
        .ent_nxt   (ent_nxt[gi])
      );
    end
  endgenerate

  // Lowest-index free slot.
  always_comb begin
    alloc_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_v[i] && (alloc_oh == '0)) alloc_oh[i] = 1'b1;
    end
  end

  assign hazard = (|raw1_v) || (|raw2_v) || (|waw_v)
               || (track && ~(|free_v))
               || (issue_uart_rd && uart_empty);

  // A squashed instruction neither stalls nor allocates; reset forces a stall.
  assign stall_i      = issue_valid && ~branch_taken && hazard;
  assign stall        = ~rst_n || stall_i;
  assign issue_accept = rst_n && issue_valid && ~branch_taken && ~stall_i;
  assign alloc_en     = issue_accept && track;
  assign alloc_v      = alloc_en ? alloc_oh : '0;

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_nxt[i].valid && (ent_nxt[i].cnt > CNT_ONE)) busy_d[ent_nxt[i].rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_mask = busy_q;

`ifdef ISSUE_SB_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                          stall_cnt_q <= '0;
    else if (stall_i && ~(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: inputs change on the falling edge and
// outputs are checked 1ns later, before the next rising edge commits state.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_rd_we;
  logic [2:0]  issue_lat;
  logic        issue_uart_rd, uart_empty, branch_taken;
  logic        stall, issue_accept;
  logic [31:0] busy_mask;
  logic [31:0] stall_cycles;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rd      (issue_rd),
    .issue_rd_we   (issue_rd_we),
    .issue_lat     (issue_lat),
    .issue_uart_rd (issue_uart_rd),
    .uart_empty    (uart_empty),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .issue_accept  (issue_accept),
    .busy_mask     (busy_mask),
    .stall_cycles  (stall_cycles)
  );

`ifdef ISSUE_SB_PERF_EN
  localparam logic [31:0] EXP_UART_STALLS = 32'd5;
`else
  localparam logic [31:0] EXP_UART_STALLS = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic [2:0] lat,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic br = 1'b0, input logic ur = 1'b0, input logic ue = 1'b0);
    issue_valid   = 1'b1;
    issue_rd      = rd;
    issue_rd_we   = we;
    issue_lat     = lat;
    issue_rs1     = rs1;
    issue_use_rs1 = u1;
    issue_rs2     = rs2;
    issue_use_rs2 = u2;
    branch_taken  = br;
    issue_uart_rd = ur;
    uart_empty    = ue;
  endtask

  task automatic op(input logic [4:0] rd, input logic we, input logic [2:0] lat,
                    input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2,
                    input logic br = 1'b0, input logic ur = 1'b0, input logic ue = 1'b0);
    @(negedge clk);
    drive(rd, we, lat, rs1, u1, rs2, u2, br, ur, ue);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      issue_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with a valid instruction present: reset override must hold it.
    rst_n = 1'b0;
    drive(5'd3, 1'b1, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_accept", 32'(issue_accept), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_valid = 1'b0;
    #1;
    chk("post_rst_busy", busy_mask, 32'h0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_cnt", stall_cycles, 32'd0);

    // 1: load x5 lat=2, dependent add stalls exactly one cycle.
    op(5'd5, 1'b1, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("t1_load_acc", 32'(issue_accept), 32'd1);
    op(5'd6, 1'b1, 3'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    chk("t1_raw_stall", 32'(stall), 32'd1);
    chk("t1_raw_acc", 32'(issue_accept), 32'd0);
    chk("t1_busy", busy_mask, 32'h20);
    op(5'd6, 1'b1, 3'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    chk("t1_release_acc", 32'(issue_accept), 32'd1);
    chk("t1_release_stall", 32'(stall), 32'd0);
    chk("t1_busy_clear", busy_mask, 32'h0);

    // RAW through rs2.
    op(5'd7, 1'b1, 3'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    op(5'd8, 1'b1, 3'd0, 5'd0, 1'b0, 5'd7, 1'b1);
    chk("rs2_raw_stall", 32'(stall), 32'd1);
    chk("rs2_busy", busy_mask, 32'h80);
    idle(3);

    // 2: x0 destination never tracked, x0 source never hazards.
    op(5'd0, 1'b1, 3'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("t2_x0_acc", 32'(issue_accept), 32'd1);
    op(5'd9, 1'b1, 3'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    chk("t2_x0_use_acc", 32'(issue_accept), 32'd1);
    chk("t2_busy", busy_mask, 32'h0);

    // lat=1 retires immediately, never a hazard.
    op(5'd14, 1'b1, 3'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    op(5'd15, 1'b1, 3'd0, 5'd14, 1'b1, 5'd0, 1'b0);
    chk("lat1_acc", 32'(issue_accept), 32'd1);
    chk("lat1_busy", busy_mask, 32'h0);

    // WAW: rd=13 lat=3, second writer waits until the first reaches cnt==1.
    op(5'd13, 1'b1, 3'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      op(5'd13, 1'b1, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("waw_acc", 32'(issue_accept), (k == 2) ? 32'd1 : 32'd0);
    end
    idle(4);

    // 3: table full with four lat=7 ops, independent lat=2 op waits for slot 0.
    for (int k = 1; k <= 4; k++) begin
      op(5'(k), 1'b1, 3'd7, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("t3_fill_acc", 32'(issue_accept), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      op(5'd9, 1'b1, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0);
      if (k == 0) chk("t3_full_busy", busy_mask, 32'h1E);
      chk("t3_full_stall", 32'(stall), (k < 3) ? 32'd1 : 32'd0);
    end
    chk("t3_full_acc", 32'(issue_accept), 32'd1);
    idle(1);
    chk("t3_busy_after", busy_mask, 32'h218);
    idle(8);

    // 5: squashed instruction neither stalls nor allocates.
    op(5'd7, 1'b1, 3'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_br_acc", 32'(issue_accept), 32'd0);
    chk("t5_br_stall", 32'(stall), 32'd0);
    idle(1);
    chk("t5_busy", busy_mask, 32'h0);

    // 6: reset clears live entries.
    op(5'd11, 1'b1, 3'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    op(5'd12, 1'b1, 3'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_pre", busy_mask, 32'h1800);
    chk("t6_rst_stall", 32'(stall), 32'd1);
    chk("t6_rst_acc", 32'(issue_accept), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0, 1'b0, 3'd0, 5'd11, 1'b1, 5'd12, 1'b1);
    #1;
    chk("t6_dep_acc", 32'(issue_accept), 32'd1);
    chk("t6_busy", busy_mask, 32'h0);
    chk("t6_cnt", stall_cycles, 32'd0);

    // 4: UART read against an empty FIFO for five cycles.
    for (int k = 0; k < 5; k++) begin
      op(5'd10, 1'b1, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("t4_uart_stall", 32'(stall), 32'd1);
    end
    op(5'd10, 1'b1, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_uart_acc", 32'(issue_accept), 32'd1);
    idle(1);
    chk("t4_stall_cnt", stall_cycles, EXP_UART_STALLS);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
